// File: rtl/spram_stream_ctrl.sv
// Write-burst capture into a single-port RAM, then in-order replay on a valid/ready read stream.
// Optional sticky overflow flag when SPRAM_STREAM_CTRL_OVERFLOW_EN is defined.
module spram_stream_ctrl #(
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048,
    parameter int DWIDTH    = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [AWIDTH-1:0] mem_address,
    output logic              mem_wren,
    output logic [DWIDTH-1:0] mem_data,
    input  logic [DWIDTH-1:0] mem_out
`ifdef SPRAM_STREAM_CTRL_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    typedef enum logic {
        S_FILL,
        S_READ
    } state_t;

    localparam logic [AWIDTH:0] LAST_ADDR = (AWIDTH + 1)'(NUM_WORDS - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic [AWIDTH:0]   r_wr_count;
    logic [AWIDTH:0]   r_rd_addr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [DWIDTH-1:0] r_fifo_data [0:1];
    logic [1:0]        r_fifo_last;
    logic              r_fifo_rd_ptr;
    logic              r_fifo_wr_ptr;
    logic [1:0]        r_fifo_count;

    logic              w_accept;
    logic              w_fill_done;
    logic              w_issue;
    logic              w_pop;
    logic [2:0]        w_occupancy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Occupancy counts buffered words plus the read in flight, net of this cycle's pop.
    assign w_occupancy = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_next_state = r_state;
        wr_ready     = 1'b0;
        busy         = 1'b0;
        mem_wren     = 1'b0;
        mem_address  = '0;
        mem_data     = '0;
        w_accept     = 1'b0;
        w_fill_done  = 1'b0;
        w_issue      = 1'b0;
        rd_valid     = !reset && (r_fifo_count != 2'd0);
        w_pop        = rd_valid && rd_ready;
        rd_data      = rd_valid ? r_fifo_data[r_fifo_rd_ptr] : '0;
        rd_last      = rd_valid && r_fifo_last[r_fifo_rd_ptr];

        if (!reset) begin
            case (r_state)
                S_FILL: begin
                    wr_ready    = 1'b1;
                    w_accept    = wr_valid;
                    mem_address = r_wr_count[AWIDTH-1:0];
                    if (w_accept) begin
                        mem_wren    = 1'b1;
                        mem_data    = wr_data;
                        w_fill_done = wr_last || (r_wr_count == LAST_ADDR);
                    end
                    if (w_fill_done) begin
                        w_next_state = S_READ;
                    end
                end
                S_READ: begin
                    busy        = 1'b1;
                    mem_address = r_rd_addr[AWIDTH-1:0];
                    w_issue     = (r_rd_addr < r_wr_count) && (w_occupancy < 3'd2);
                    if (w_pop && rd_last) begin
                        w_next_state = S_FILL;
                    end
                end
                default: w_next_state = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count    <= '0;
            r_rd_addr     <= '0;
            r_inflight    <= 1'b0;
            r_fifo_rd_ptr <= 1'b0;
            r_fifo_wr_ptr <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (r_inflight) begin
                r_fifo_wr_ptr <= ~r_fifo_wr_ptr;
            end
            if (w_pop) begin
                r_fifo_rd_ptr <= ~r_fifo_rd_ptr;
            end
            r_fifo_count <= r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
            if (r_state == S_READ && w_next_state == S_FILL) begin
                r_wr_count <= '0;
                r_rd_addr  <= '0;
            end
        end
    end

    // NOTE: storage needs no reset; validity is carried entirely by the reset count and pointers.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_inflight_last <= (r_rd_addr + 1'b1 == r_wr_count);
        end
        if (r_inflight) begin
            r_fifo_data[r_fifo_wr_ptr] <= mem_out;
            r_fifo_last[r_fifo_wr_ptr] <= r_inflight_last;
        end
    end

`ifdef SPRAM_STREAM_CTRL_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_accept && !wr_last && r_wr_count == LAST_ADDR) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
